// File: rtl/btn_debouncer.sv
// btn_debouncer
//   Cleans up raw keypad/button inputs for the lock FSM. The raw pins are
//   synchronised into the clk_in domain. An internal counter produces a
//   one-cycle sample strobe (tick), so no divided clock is ever used as a
//   clock. On each tick, every button is compared with its debounced level.
//   The level only changes after STABLE_CNT consecutive mismatching ticks.
//   One-cycle press/release pulses are registered alongside the level.
//
// Ports
//   clk_in       in   1        system clock
//   rst          in   1        synchronous reset, active-high
//   btn_raw      in   NUM_BTN  asynchronous raw button inputs, 1 = pressed
//   btn_level    out  NUM_BTN  debounced level (registered)
//   btn_press    out  NUM_BTN  one-cycle pulse on each debounced 0->1
//   btn_release  out  NUM_BTN  one-cycle pulse on each debounced 1->0
//   tick         out  1        one-cycle sample strobe, period TICK_DIV
module btn_debouncer #(
  parameter int NUM_BTN    = 4,
  parameter int TICK_DIV   = 125000,
  parameter int STABLE_CNT = 4,
  parameter int CNT_W      = 17
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic               tick
);

  localparam int SC_W = $clog2(STABLE_CNT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [SC_W-1:0]  STAB_LAST = SC_W'(STABLE_CNT - 1);

  // Sample-strobe divider
  logic [CNT_W-1:0] cnt_reg;

  // The strobe is decoded straight from the counter. It is therefore high
  // in exactly the cycle where cnt_reg == TICK_DIV-1.
  assign tick = (cnt_reg == CNT_LAST);

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  // Two-flop synchroniser for the asynchronous pins
  logic [NUM_BTN-1:0] sync1_reg;
  logic [NUM_BTN-1:0] sync2_reg;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= btn_raw;
      sync2_reg <= sync1_reg;
    end
  end

  // Per-button stability counter, level and edge pulses
  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    logic [SC_W-1:0] stab_reg;
    logic [SC_W-1:0] stab_next;
    logic            level_reg;
    logic            level_next;
    logic            press_reg;
    logic            press_next;
    logic            release_reg;
    logic            release_next;

    always_comb begin
      stab_next    = stab_reg;
      level_next   = level_reg;
      press_next   = 1'b0;
      release_next = 1'b0;
      if (tick) begin
        if (sync2_reg[gi] == level_reg) begin
          // Any agreeing sample breaks the run of mismatches.
          stab_next = '0;
        end else if (stab_reg == STAB_LAST) begin
          // This tick completes the run of STABLE_CNT mismatches.
          stab_next    = '0;
          level_next   = sync2_reg[gi];
          press_next   = sync2_reg[gi];
          release_next = ~sync2_reg[gi];
        end else begin
          stab_next = stab_reg + SC_W'(1);
        end
      end
    end

    always_ff @(posedge clk_in) begin
      if (rst) begin
        stab_reg    <= '0;
        level_reg   <= 1'b0;
        press_reg   <= 1'b0;
        release_reg <= 1'b0;
      end else begin
        stab_reg    <= stab_next;
        level_reg   <= level_next;
        press_reg   <= press_next;
        release_reg <= release_next;
      end
    end

    assign btn_level[gi]   = level_reg;
    assign btn_press[gi]   = press_reg;
    assign btn_release[gi] = release_reg;
  end

endmodule

// File: tb/tb_btn_debouncer.sv
// Bench for btn_debouncer with NUM_BTN=4, TICK_DIV=4, STABLE_CNT=3.
// Cycle n is the clock period ending at posedge n. Cycle 0 is the first
// posedge with rst low. Outputs are sampled 1 time unit after the previous
// edge, so the values seen in cycle n are those produced by edge n-1.
module tb_btn_debouncer;

  localparam int NB = 4;
  localparam int TD = 4;
  localparam int SC = 3;
  localparam int CW = 3;

  logic          clk_in = 1'b0;
  logic          rst    = 1'b1;
  logic [NB-1:0] btn_raw = '0;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;
  logic          tick;

  btn_debouncer #(
    .NUM_BTN    (NB),
    .TICK_DIV   (TD),
    .STABLE_CNT (SC),
    .CNT_W      (CW)
  ) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .tick        (tick)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // One run of identical cycles: raw input held, expected outputs constant.
  typedef struct {
    bit         rst_first;
    int         ncyc;
    logic [3:0] raw;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rel;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit r, int n, logic [3:0] raw, logic [3:0] lvl,
                              logic [3:0] prs, logic [3:0] rel);
    vec_t v;
    v.rst_first = r;
    v.ncyc      = n;
    v.raw       = raw;
    v.lvl       = lvl;
    v.prs       = prs;
    v.rel       = rel;
    tbl.push_back(v);
  endfunction

  task automatic step();
    @(posedge clk_in);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] lvl, input logic [3:0] prs,
                            input logic [3:0] rel, input logic tk);
    chk({tag, ".level"},   32'(btn_level),   32'(lvl));
    chk({tag, ".press"},   32'(btn_press),   32'(prs));
    chk({tag, ".release"}, 32'(btn_release), 32'(rel));
    chk({tag, ".tick"},    32'(tick),        32'(tk));
  endtask

  // Holds rst for 5 edges with inputs low and checks all outputs stay 0.
  // On return we are in cycle 0 with rst low.
  task automatic do_reset();
    rst     = 1'b1;
    btn_raw = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_outs("reset", 4'h0, 4'h0, 4'h0, 1'b0);
    end
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Single press, then a 2-tick dropout that is filtered out, then a real release.
    // Raw goes low at 13: sync2 is low during cycles 15..20, seen by ticks 15 and 19 only.
    // Raw goes low again at 28: mismatch at ticks 31, 35 and 39, so level drops at 40.
    add(1, 12, 4'b0001, 4'b0000, 4'b0000, 4'b0000); // cycles 0..11
    add(0,  1, 4'b0001, 4'b0001, 4'b0001, 4'b0000); // cycle 12: press
    add(0,  6, 4'b0000, 4'b0001, 4'b0000, 4'b0000); // cycles 13..18: dropout
    add(0,  9, 4'b0001, 4'b0001, 4'b0000, 4'b0000); // cycles 19..27
    add(0, 12, 4'b0000, 4'b0001, 4'b0000, 4'b0000); // cycles 28..39
    add(0,  1, 4'b0000, 4'b0000, 4'b0000, 4'b0001); // cycle 40: release
    add(0,  2, 4'b0000, 4'b0000, 4'b0000, 4'b0000); // cycles 41..42
    // Two buttons together: 1010 for 20 cycles, then 0000.
    add(1, 12, 4'b1010, 4'b0000, 4'b0000, 4'b0000); // cycles 0..11
    add(0,  1, 4'b1010, 4'b1010, 4'b1010, 4'b0000); // cycle 12: both press
    add(0,  7, 4'b1010, 4'b1010, 4'b0000, 4'b0000); // cycles 13..19
    add(0, 12, 4'b0000, 4'b1010, 4'b0000, 4'b0000); // cycles 20..31
    add(0,  1, 4'b0000, 4'b0000, 4'b0000, 4'b1010); // cycle 32: both release
    add(0,  2, 4'b0000, 4'b0000, 4'b0000, 4'b0000); // cycles 33..34

    foreach (tbl[k]) begin
      if (tbl[k].rst_first) do_reset();
      for (int c = 0; c < tbl[k].ncyc; c++) begin
        btn_raw = tbl[k].raw;
        check_outs("vec", tbl[k].lvl, tbl[k].prs, tbl[k].rel, (cyc % TD) == TD - 1);
        step();
      end
      $display("vec %0d: raw=%b cycles=%0d level=%b press=%b release=%b",
               k, tbl[k].raw, tbl[k].ncyc, tbl[k].lvl, tbl[k].prs, tbl[k].rel);
    end

    // Reset in the middle of a debounce. Ticks 3 and 7 have already counted
    // two mismatches, so a surviving count would raise the level early.
    do_reset();
    btn_raw = 4'b0001;
    repeat (9) step();
    rst = 1'b1;
    step();
    check_outs("midrst", 4'h0, 4'h0, 4'h0, 1'b0);
    rst = 1'b0;
    cyc = 0;
    for (int i = 0; i < 14; i++) begin
      check_outs("restart", (cyc >= 12) ? 4'b0001 : 4'b0000,
                 (cyc == 12) ? 4'b0001 : 4'b0000, 4'b0000, (cyc % TD) == TD - 1);
      step();
    end
    $display("seq midrst: level[0] checked through restart cycle 13");

    // Chatter on bit 2 toggling every 3 cycles. No three consecutive ticks
    // ever see the same value, so the level must never move.
    do_reset();
    for (int i = 0; i < 100; i++) begin
      btn_raw = (((i / 3) % 2) != 0) ? 4'b0100 : 4'b0000;
      check_outs("chatter", 4'h0, 4'h0, 4'h0, (cyc % TD) == TD - 1);
      step();
    end
    btn_raw = '0;
    for (int i = 0; i < 8; i++) begin
      check_outs("chatter_end", 4'h0, 4'h0, 4'h0, (cyc % TD) == TD - 1);
      step();
    end
    $display("seq chatter: 100 cycles of toggling on bit 2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
